// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO port arbiter for instruction fetch and load/store traffic.
// Multi-byte accesses are split into little-endian byte transfers; MEM has priority over IF.
module mem_ctrl #(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_done,
  output logic        if_stall,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_stall,
  input  logic        io_buffer_full,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;  // 1 = MEM, 0 = IF
  logic [2:0]  len_q, len_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d;
  logic [31:0] ram_a_q, ram_a_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic        ram_wr_q, ram_wr_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;

  logic        io_block;
  logic [2:0]  mem_len;
  logic [2:0]  step;
  logic [1:0]  byte_idx;
  logic [4:0]  bit_lo;

  assign io_block = mem_we & (mem_addr[17:16] == IO_HI) & io_buffer_full;
  assign mem_len  = (mem_size == 2'd0) ? 3'd1 : (mem_size == 2'd1) ? 3'd2 : 3'd4;
  // step = number of edges since the accept edge, for the edge being evaluated
  assign step     = cnt_q + 3'd1;
  assign byte_idx = 2'(step - 3'd2);
  assign bit_lo   = {byte_idx, 3'b000};

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mem_req && !io_block) begin
          owner_d = 1'b1;
          len_d   = mem_len;
          cnt_d   = 3'd0;
          ram_a_d = mem_addr;
          if (mem_we) begin
            state_d    = StWrite;
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata[7:0];
            sh_d       = {8'h00, mem_wdata[31:8]};
          end else begin
            state_d = StRead;
            sh_d    = 32'h0;
          end
        end else if (if_req) begin
          owner_d = 1'b0;
          len_d   = 3'd4;
          cnt_d   = 3'd0;
          ram_a_d = if_addr;
          state_d = StRead;
          sh_d    = 32'h0;
        end
      end

      StRead: begin
        if (flush && !owner_q) begin
          state_d = StIdle;
        end else begin
          cnt_d = step;
          if (step < len_q) ram_a_d = ram_a_q + 32'd1;
          // RAM answers one edge after the address, so byte k lands at step k+2
          if (step >= 3'd2) sh_d[bit_lo +: 8] = ram_din;
          if (step == len_q + 3'd1) begin
            state_d = StDone;
            if (owner_q) begin
              mem_done_d  = 1'b1;
              mem_rdata_d = sh_d;
            end else begin
              if_done_d = 1'b1;
              if_data_d = sh_d;
            end
          end
        end
      end

      StWrite: begin
        if (step < len_q) begin
          cnt_d      = step;
          ram_wr_d   = 1'b1;
          ram_a_d    = ram_a_q + 32'd1;
          ram_dout_d = sh_q[7:0];
          sh_d       = {8'h00, sh_q[31:8]};
        end else begin
          state_d    = StDone;
          mem_done_d = 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      len_q       <= 3'd0;
      cnt_q       <= 3'd0;
      sh_q        <= 32'h0;
      ram_a_q     <= 32'h0;
      ram_dout_q  <= 8'h0;
      ram_wr_q    <= 1'b0;
      if_data_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign if_data   = if_data_q;
  assign if_done   = if_done_q;
  assign if_stall  = if_req & ~if_done_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_done  = mem_done_q;
  assign mem_stall = mem_req & ~mem_done_q;
  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: a synchronous byte RAM model answers one edge after the address.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        if_stall;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_stall;
  logic        io_buffer_full;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  logic [7:0]  ram [0:262143];
  logic        pl_en;
  logic [17:0] pl_addr;
  logic [7:0]  pl_data;
  int          wr_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          lat;
  int          wr_base;

  always #5 clk = ~clk;

  mem_ctrl #(.IO_HI(2'b11)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_data        (if_data),
    .if_done        (if_done),
    .if_stall       (if_stall),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_size       (mem_size),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_done       (mem_done),
    .mem_stall      (mem_stall),
    .io_buffer_full (io_buffer_full),
    .ram_din        (ram_din),
    .ram_dout       (ram_dout),
    .ram_a          (ram_a),
    .ram_wr         (ram_wr)
  );

  // Single writer of the RAM array: preload port or DUT write strobe.
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (ram_wr) ram[ram_a[17:0]] <= ram_dout;
    ram_din <= ram[ram_a[17:0]];
  end

  always @(negedge clk) if (ram_wr) wr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic poke(input logic [17:0] a, input logic [7:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Returns edges from the first posedge (the accept edge) until done is seen; -1 on timeout.
  task automatic wait_done(input bit is_mem, output int l);
    l = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (is_mem ? mem_done : if_done) begin
        l = c - 1;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = '0; mem_addr = '0; mem_wdata = '0;
    io_buffer_full = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    poke(18'h00100, 8'h13); poke(18'h00101, 8'h05);
    poke(18'h00102, 8'h10); poke(18'h00103, 8'h00);
    poke(18'h00200, 8'h11); poke(18'h00201, 8'h22);
    poke(18'h00202, 8'h33); poke(18'h00203, 8'h44);
    poke(18'h00040, 8'h7F); poke(18'h3FFFF, 8'h9A);
    poke(18'h00000, 8'h5B); poke(18'h02004, 8'h00);
    poke(18'h30000, 8'h00);

    @(negedge clk);
    check("rst_ram_a", ram_a, 32'h0);
    check("rst_ram_wr", {31'h0, ram_wr}, 32'h0);
    check("rst_dones", {30'h0, if_done, mem_done}, 32'h0);
    check("rst_data", if_data | mem_rdata | {24'h0, ram_dout}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word fetch
    wr_base = wr_cnt;
    if_req = 1'b1; if_addr = 32'h100;
    #1 check("fetch_stall", {31'h0, if_stall}, 32'h1);
    wait_done(1'b0, lat);
    check("fetch_lat", lat, 5);
    check("fetch_data", if_data, 32'h00100513);
    check("fetch_no_wr", wr_cnt - wr_base, 0);
    if_req = 1'b0;
    @(negedge clk);

    // Half store, little-endian
    wr_base = wr_cnt;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd1;
    mem_addr = 32'h2002; mem_wdata = 32'hDEADBEEF;
    wait_done(1'b1, lat);
    check("sth_lat", lat, 2);
    check("sth_nwr", wr_cnt - wr_base, 2);
    check("sth_b0", {24'h0, ram[18'h02002]}, 32'hEF);
    check("sth_b1", {24'h0, ram[18'h02003]}, 32'hBE);
    check("sth_b2", {24'h0, ram[18'h02004]}, 32'h00);
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);

    // Contention: MEM byte load wins, IF waits until after DONE->IDLE
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h40;
    if_req = 1'b1; if_addr = 32'h200;
    wait_done(1'b1, lat);
    check("cont_mem_lat", lat, 2);
    check("cont_rdata", mem_rdata, 32'h0000007F);
    check("cont_if_stall", {30'h0, if_stall, if_done}, 32'h2);
    mem_req = 1'b0;
    // leave-DONE edge, accept edge, then 5 cycles to if_done
    wait_done(1'b0, lat);
    check("cont_if_lat", lat, 6);
    check("cont_if_data", if_data, 32'h44332211);
    if_req = 1'b0;
    @(negedge clk);

    // IO store held while buffer full
    wr_base = wr_cnt;
    io_buffer_full = 1'b1;
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd0;
    mem_addr = 32'h0003_0000; mem_wdata = 32'h123456A5;
    lat = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_done) lat++;
    end
    check("io_hold_nwr", wr_cnt - wr_base, 0);
    check("io_hold_done", lat, 0);
    check("io_hold_stall", {31'h0, mem_stall}, 32'h1);
    io_buffer_full = 1'b0;
    wait_done(1'b1, lat);
    check("io_lat", lat, 1);
    check("io_byte", {24'h0, ram[18'h30000]}, 32'hA5);
    check("io_nwr", wr_cnt - wr_base, 1);
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);

    // Flush at accept+2, redirect to 0x200
    if_req = 1'b1; if_addr = 32'h100;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1; if_addr = 32'h200;
    @(negedge clk);
    flush = 1'b0;
    // idle after the flush edge, re-accept on the next, done 5 later
    wait_done(1'b0, lat);
    check("flush_lat", lat, 5);
    check("flush_data", if_data, 32'h44332211);
    if_req = 1'b0;
    @(negedge clk);

    // Half load wrapping the 32-bit address space
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd1; mem_addr = 32'hFFFF_FFFF;
    wait_done(1'b1, lat);
    check("wrap_lat", lat, 3);
    check("wrap_data", mem_rdata, 32'h00005B9A);
    mem_req = 1'b0;
    @(negedge clk);

    // Async reset at accept+2 of a word store
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2;
    mem_addr = 32'h3000; mem_wdata = 32'h01020304;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_rst_wr", {31'h0, ram_wr}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_ram_wr", {31'h0, ram_wr}, 32'h0);
    check("arst_ram_a", ram_a, 32'h0);
    check("arst_dout", {24'h0, ram_dout}, 32'h0);
    check("arst_rdata", mem_rdata, 32'h0);
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // size 3 behaves as a word
    mem_req = 1'b1; mem_size = 2'd3; mem_addr = 32'h100;
    wait_done(1'b1, lat);
    check("post_rst_lat", lat, 5);
    check("post_rst_data", mem_rdata, 32'h00100513);
    mem_req = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
